// File: rtl/sac_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encodings,
// default operand width and the signed-overflow helper.
package sac_pkg;

  localparam int SAC_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sac_state_e;

  // Signed overflow: carry into the MSB differs from carry out of the MSB.
  function automatic logic sac_ovf(input logic c_into_msb, input logic c_out_msb);
    return c_into_msb ^ c_out_msb;
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Single 1-bit full-adder cell, purely combinational; time-shared by the
// serial adder controller across all bit positions.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: steps one fa_cell LSB-first, one bit per clock,
// then presents sum, carry-out and signed overflow with a one-cycle done pulse.
module serial_add_ctrl
  import sac_pkg::*;
#(
  parameter int WIDTH = SAC_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_BIT  = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  sac_state_e       state_r;
  sac_state_e       state_nx_s;
  logic             load_s;
  logic             step_s;
  logic             last_s;

  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic             c_msb_in_r;

  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;

  logic             cell_s_s;
  logic             cell_co_s;

  fa_cell u_fa_cell (
    .a  (a_sh_r[0]),
    .b  (b_sh_r[0]),
    .ci (carry_r),
    .s  (cell_s_s),
    .co (cell_co_s)
  );

  // Next-state and datapath strobes.
  always_comb begin
    state_nx_s = state_r;
    load_s     = 1'b0;
    step_s     = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_RUN;
          load_s     = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        if (cnt_r == LAST_BIT) begin
          last_s     = 1'b1;
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State register plus registered busy/done derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != ST_IDLE);
      done_r  <= (state_nx_s == ST_DONE);
    end
  end

  // Operand shifters, running carry, bit counter and partial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r     <= '0;
      b_sh_r     <= '0;
      sum_sh_r   <= '0;
      carry_r    <= 1'b0;
      cnt_r      <= '0;
      c_msb_in_r <= 1'b0;
    end else if (load_s) begin
      a_sh_r     <= a;
      b_sh_r     <= b;
      sum_sh_r   <= '0;
      carry_r    <= cin;
      cnt_r      <= '0;
      c_msb_in_r <= 1'b0;
    end else if (step_s) begin
      a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
      b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
      sum_sh_r <= {cell_s_s, sum_sh_r[WIDTH-1:1]};
      carry_r  <= cell_co_s;
      // Hold the counter on the last bit so it never wraps mid-operation.
      if (!last_s) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
      if (cnt_r == PRE_BIT) begin
        c_msb_in_r <= cell_co_s;
      end
    end
  end

  // Result registers update only on the RUN to DONE transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (last_s) begin
      sum_r  <= {cell_s_s, sum_sh_r[WIDTH-1:1]};
      cout_r <= cell_co_s;
      ovf_r  <= sac_ovf(c_msb_in_r, cell_co_s);
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed, random,
// ignored-start, reset-abort and back-to-back scenarios against a plain-arithmetic model.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int errors;
  int checks;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {cout,sum} = a+b+cin; overflow when equal-sign operands give other-sign sum.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rc);
    logic [W:0] full;
    logic       v;
    full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
    v    = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
    return {v, full};
  endfunction

  // Issue one add and wait (bounded) for done; lat = edges from accept edge to done sample.
  task automatic do_add(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                        output int lat, output logic [W-1:0] rs, output logic rc, output logic ro);
    int n;
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    lat = n; rs = sum; rc = cout; ro = ovf;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, sum, cout, ovf} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all zero",
               busy, done, sum, cout, ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [5] = '{8'h5A, 8'hFF, 8'hFF, 8'h80, 8'h00};
    logic [W-1:0] tb [5] = '{8'h3C, 8'h01, 8'h00, 8'h80, 8'h00};
    logic         tc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] es [5] = '{8'h96, 8'h00, 8'h00, 8'h00, 8'h00};
    logic         ec [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic         eo [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int lat; logic [W-1:0] rs; logic rc, ro;
    for (int i = 0; i < 5; i++) begin
      do_add(ta[i], tb[i], tc[i], lat, rs, rc, ro);
      checks++;
      if (lat !== W) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d edges, expected %0d", i, lat, W);
      end
      checks++;
      if ({rs, rc, ro} !== {es[i], ec[i], eo[i]}) begin
        errors++;
        $display("FAIL directed_result[%0d]: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                 i, rs, rc, ro, es[i], ec[i], eo[i]);
      end
    end
  endtask

  task automatic test_random;
    int lat; logic [W-1:0] rs; logic rc, ro;
    logic [W-1:0] ra, rb; logic rci; logic [W+1:0] exp;
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom); rb = W'($urandom); rci = 1'($urandom);
      exp = ref_add(ra, rb, rci);
      do_add(ra, rb, rci, lat, rs, rc, ro);
      checks++;
      if (lat !== W || {ro, rc, rs} !== exp) begin
        errors++;
        $display("FAIL random[%0d] %h+%h+%b: got lat=%0d ovf=%b cout=%b sum=%h, expected lat=%0d ovf=%b cout=%b sum=%h",
                 i, ra, rb, rci, lat, ro, rc, rs, W, exp[W+1], exp[W], exp[W-1:0]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int dones;
    logic [W-1:0] held;
    @(negedge clk);
    a = 8'h23; b = 8'h45; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    held = '0;
    for (int n = 0; n < 20; n++) begin
      checks++;
      if (busy !== (n <= W)) begin
        errors++;
        $display("FAIL ignore_busy[%0d]: got %b, expected %b", n, busy, (n <= W));
      end
      if (done) begin
        dones++;
        held = sum;
      end
      if (n == 3) begin
        start = 1'b1; a = 8'h01; b = 8'h01;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (dones !== 1 || held !== 8'h68) begin
      errors++;
      $display("FAIL ignore_start: got dones=%0d sum=%h, expected dones=1 sum=68", dones, held);
    end
  endtask

  task automatic test_reset_abort;
    int lat; logic [W-1:0] rs; logic rc, ro;
    int dones;
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, cout, ovf} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL abort_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all zero",
               busy, done, sum, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d busy/done cycles, expected 0", dones);
    end
    do_add(8'h12, 8'h34, 1'b0, lat, rs, rc, ro);
    checks++;
    if (rs !== 8'h46 || lat !== W) begin
      errors++;
      $display("FAIL abort_restart: got sum=%h lat=%0d, expected sum=46 lat=%0d", rs, lat, W);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] ha [60];
    logic [W-1:0] hb [60];
    logic         hc [60];
    logic [W+1:0] exp;
    logic [W-1:0] last_sum;
    int last_done;
    int dones;
    logic prev_done;
    last_done = -1; dones = 0; prev_done = 1'b0; last_sum = '0;
    @(negedge clk);
    start = 1'b1;
    for (int e = 0; e < 60; e++) begin
      ha[e] = W'($urandom); hb[e] = W'($urandom); hc[e] = 1'($urandom);
      a = ha[e]; b = hb[e]; cin = hc[e];
      @(negedge clk);
      if (done) begin
        dones++;
        checks++;
        if (prev_done) begin
          errors++;
          $display("FAIL b2b_width: done high on consecutive cycles at edge %0d", e);
        end
        if (e >= W) begin
          exp = ref_add(ha[e-W], hb[e-W], hc[e-W]);
          checks++;
          if ({ovf, cout, sum} !== exp) begin
            errors++;
            $display("FAIL b2b_result[%0d]: got ovf=%b cout=%b sum=%h, expected ovf=%b cout=%b sum=%h",
                     e, ovf, cout, sum, exp[W+1], exp[W], exp[W-1:0]);
          end
        end
        if (last_done >= 0) begin
          checks++;
          if (e - last_done !== W + 2) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d edges between dones, expected %0d", e - last_done, W + 2);
          end
        end
        last_done = e;
        last_sum  = sum;
      end else if (last_done >= 0) begin
        checks++;
        if (sum !== last_sum) begin
          errors++;
          $display("FAIL b2b_stable[%0d]: got sum=%h, expected held %h", e, sum, last_sum);
        end
      end
      prev_done = done;
    end
    start = 1'b0;
    checks++;
    if (dones !== 6) begin
      errors++;
      $display("FAIL b2b_count: got %0d dones, expected 6", dones);
    end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
